// File: rtl/axis_diff_ctrl_if.sv
// Stream bundle around the differentiator controller: the differentiator's
// output stream (in_*) and the downstream AXI-Stream master (out_*).
interface axis_diff_ctrl_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic                        in_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] in_tdata;
    logic                        out_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] out_tdata;
    logic                        out_tready;

    modport slave (
        input  in_tvalid,
        input  in_tdata,
        output out_tvalid,
        output out_tdata,
        input  out_tready
    );

    modport master (
        output in_tvalid,
        output in_tdata,
        input  out_tvalid,
        input  out_tdata,
        output out_tready
    );
endinterface

// File: rtl/axis_diff_ctrl.sv
// Sequencer for a streaming differentiator: clears its history, discards the fill
// beats, then forwards through a one-entry output register. The drop counter is
// built only when AXIS_DIFF_CTRL_DROP_CNT_EN is defined.
//
// state  | meaning
// BYPASS | differentiator idle, input beats forwarded
// CLEAR  | one cycle with diff_aresetn low, beats discarded
// FILL   | differentiator running, FILL_BEATS beats discarded
// RUN    | differentiator output trusted, beats forwarded
module axis_diff_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FILL_BEATS       = 6
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable_req,
    output logic                 diff_enable,
    output logic                 diff_aresetn,
    output logic [1:0]           state,
    output logic [15:0]          drop_count,
    axis_diff_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        CLEAR  = 2'd1,
        FILL   = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam logic [7:0] FILL_LAST = 8'(FILL_BEATS - 1);

    state_e                      state_q, state_d;
    logic [7:0]                  fill_cnt_q, fill_cnt_d;
    logic                        forward;
    logic                        accept;
    logic                        out_valid_q, out_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= BYPASS;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // A dropped enable_req wins over every other transition.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = '0;
        case (state_q)
            BYPASS: if (enable_req) state_d = CLEAR;
            CLEAR:  state_d = enable_req ? FILL : BYPASS;
            FILL: begin
                if (bus.in_tvalid) fill_cnt_d = fill_cnt_q + 8'd1;
                else               fill_cnt_d = fill_cnt_q;
                if (!enable_req)
                    state_d = BYPASS;
                else if (bus.in_tvalid && fill_cnt_q == FILL_LAST)
                    state_d = RUN;
            end
            RUN:    if (!enable_req) state_d = BYPASS;
            default: state_d = BYPASS;
        endcase
    end

    always_comb begin
        diff_enable  = 1'b0;
        diff_aresetn = 1'b1;
        forward      = 1'b0;
        case (state_q)
            BYPASS: forward = bus.in_tvalid;
            CLEAR:  diff_aresetn = 1'b0;
            FILL:   diff_enable = 1'b1;
            RUN: begin
                diff_enable = 1'b1;
                forward     = bus.in_tvalid;
            end
            default: ;
        endcase
    end

    assign accept = !out_valid_q || bus.out_tready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (forward && accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_tdata;
        end else if (bus.out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef AXIS_DIFF_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (forward && !accept && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk) begin
        if (areset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign state          = state_q;
    assign bus.out_tvalid = out_valid_q;
    assign bus.out_tdata  = out_data_q;
endmodule

// File: tb/tb_axis_diff_ctrl.sv
// Directed bench for axis_diff_ctrl: bypass, enable sequencing, stall drops,
// abort during fill, drop counter saturation and reset in RUN.
module tb_axis_diff_ctrl;
    localparam int W = 32;

`ifdef AXIS_DIFF_CTRL_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP3   = 16'd3;
    localparam logic [15:0] EXP_DROP102 = 16'd102;
    localparam logic [15:0] EXP_SAT     = 16'hFFFF;
`else
    localparam logic [15:0] EXP_DROP3   = 16'd0;
    localparam logic [15:0] EXP_DROP102 = 16'd0;
    localparam logic [15:0] EXP_SAT     = 16'd0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable_req;
    logic        diff_enable;
    logic        diff_aresetn;
    logic [1:0]  state;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    axis_diff_ctrl_if #(.AXIS_TDATA_WIDTH(W)) bus ();

    axis_diff_ctrl #(.AXIS_TDATA_WIDTH(W), .FILL_BEATS(6)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .enable_req   (enable_req),
        .diff_enable  (diff_enable),
        .diff_aresetn (diff_aresetn),
        .state        (state),
        .drop_count   (drop_count),
        .bus          (bus.slave)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [31:0] d);
        bus.in_tvalid = v;
        bus.in_tdata  = d;
    endtask

    initial begin
        areset         = 1'b1;
        enable_req     = 1'b0;
        bus.in_tvalid  = 1'b0;
        bus.in_tdata   = '0;
        bus.out_tready = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tvalid", 32'(bus.out_tvalid), 32'd0);
        chk("rst_tdata", bus.out_tdata, 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_diff_en", 32'(diff_enable), 32'd0);
        chk("rst_diff_rstn", 32'(diff_aresetn), 32'd1);
        areset = 1'b0;

        // bypass: beats 1..10 appear one cycle later
        for (int i = 1; i <= 10; i++) begin
            beat(1'b1, 32'(i));
            tick();
            chk("byp_tvalid", 32'(bus.out_tvalid), 32'd1);
            chk("byp_tdata", bus.out_tdata, 32'(i));
            chk("byp_state", 32'(state), 32'd0);
        end
        beat(1'b0, 32'd0);
        tick();
        chk("byp_drain", 32'(bus.out_tvalid), 32'd0);

        // enable sequence: CLEAR then 6 FILL beats discarded
        enable_req = 1'b1;
        tick();
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_diff_rstn", 32'(diff_aresetn), 32'd0);
        chk("clr_diff_en", 32'(diff_enable), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            beat(1'b1, 32'(i));
            tick();
            if (i <= 6) begin
                chk("fill_state", 32'(state), 32'd2);
                chk("fill_diff_rstn", 32'(diff_aresetn), 32'd1);
                chk("fill_diff_en", 32'(diff_enable), 32'd1);
            end else begin
                chk("run_state", 32'(state), 32'd3);
            end
            if (i <= 7) begin
                chk("fill_discard", 32'(bus.out_tvalid), 32'd0);
            end else begin
                chk("run_tvalid", 32'(bus.out_tvalid), 32'd1);
                chk("run_tdata", bus.out_tdata, 32'(i));
            end
        end
        beat(1'b0, 32'd0);
        tick();
        chk("run_drain", 32'(bus.out_tvalid), 32'd0);

        // stall in RUN: first beat held, next three dropped
        bus.out_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 32'(100 + i));
            tick();
            chk("stall_tvalid", 32'(bus.out_tvalid), 32'd1);
            chk("stall_tdata", bus.out_tdata, 32'd100);
        end
        chk("stall_drop", 32'(drop_count), 32'(EXP_DROP3));
        beat(1'b0, 32'd0);
        bus.out_tready = 1'b1;
        tick();
        chk("stall_drain", 32'(bus.out_tvalid), 32'd0);
        chk("stall_drop_hold", 32'(drop_count), 32'(EXP_DROP3));

        // leave RUN, then abort a fill after 3 beats
        enable_req = 1'b0;
        tick();
        chk("run_off_state", 32'(state), 32'd0);
        enable_req = 1'b1;
        tick();
        chk("ab_clr", 32'(state), 32'd1);
        tick();
        chk("ab_fill", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 32'(20 + i));
            tick();
            chk("ab_fill_discard", 32'(bus.out_tvalid), 32'd0);
        end
        beat(1'b0, 32'd0);
        enable_req = 1'b0;
        tick();
        chk("ab_state", 32'(state), 32'd0);
        chk("ab_diff_en", 32'(diff_enable), 32'd0);
        beat(1'b1, 32'd24);
        tick();
        chk("ab_fwd_tvalid", 32'(bus.out_tvalid), 32'd1);
        chk("ab_fwd_tdata", bus.out_tdata, 32'd24);
        beat(1'b0, 32'd0);
        enable_req = 1'b1;
        tick();
        chk("re_clr", 32'(state), 32'd1);
        tick();
        chk("re_fill", 32'(state), 32'd2);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 32'(30 + i));
            tick();
            chk("re_state", 32'(state), (i < 5) ? 32'd2 : 32'd3);
            chk("re_discard", 32'(bus.out_tvalid), 32'd0);
        end
        beat(1'b1, 32'd36);
        tick();
        chk("re_run_tdata", bus.out_tdata, 32'd36);
        chk("re_run_tvalid", 32'(bus.out_tvalid), 32'd1);
        beat(1'b0, 32'd0);
        tick();

        // saturation: 70000 forwarded beats against a stalled output
        bus.out_tready = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            beat(1'b1, 32'(1000 + i));
            tick();
            if (i == 99) chk("sat_mid", 32'(drop_count), 32'(EXP_DROP102));
        end
        chk("sat_drop", 32'(drop_count), 32'(EXP_SAT));
        chk("sat_tdata", bus.out_tdata, 32'd1000);
        chk("sat_state", 32'(state), 32'd3);
        chk("sat_tvalid", 32'(bus.out_tvalid), 32'd1);

        // reset in RUN with a pending beat
        beat(1'b0, 32'd0);
        areset = 1'b1;
        tick();
        chk("rr_tvalid", 32'(bus.out_tvalid), 32'd0);
        chk("rr_state", 32'(state), 32'd0);
        chk("rr_drop", 32'(drop_count), 32'd0);
        chk("rr_diff_en", 32'(diff_enable), 32'd0);
        chk("rr_tdata", bus.out_tdata, 32'd0);
        areset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_diff_ctrl.md
AXIS_DIFF_CTRL -- requirements
Module: axis_diff_ctrl

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32: width of in/out stream data.
REQ-002 The block SHALL have parameter FILL_BEATS, default 6: differentiator beats discarded after enable before output is trusted (range 1..255).
REQ-003 The block SHALL have port aclk, input, 1: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port areset, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable_req, input, 1: software request to run the differentiator (level).
REQ-006 The block SHALL have port diff_enable, output, 1: drives the differentiator enable input.
REQ-007 The block SHALL have port diff_aresetn, output, 1: drives the differentiator aresetn to clear its history.
REQ-008 The block SHALL have ports in_tvalid, input, 1 and in_tdata, input, AXIS_TDATA_WIDTH: differentiator master output; no backpressure exists.
REQ-009 The block SHALL have ports out_tvalid, output, 1; out_tdata, output, AXIS_TDATA_WIDTH; out_tready, input, 1: downstream AXI-Stream master.
REQ-010 The block SHALL have port state, output, 2: current FSM state encoding (BYPASS=0, CLEAR=1, FILL=2, RUN=3).
REQ-011 The block SHALL have port drop_count, output, 16: saturating count of beats lost to downstream stall.

Function
REQ-012 The FSM SHALL have states BYPASS, CLEAR, FILL and RUN.
REQ-013 BYPASS: diff_enable=0, diff_aresetn=1; in beats forwarded; enable_req=1 -> CLEAR next cycle.
REQ-014 CLEAR: lasts exactly 1 cycle; diff_aresetn=0, diff_enable=0; in beats discarded; then FILL if enable_req=1, else BYPASS.
REQ-015 FILL: diff_enable=1, diff_aresetn=1; in beats discarded and counted; after the FILL_BEATS-th beat -> RUN next cycle; the counter SHALL clear on entry.
REQ-016 RUN: diff_enable=1; in beats forwarded.
REQ-017 In CLEAR, FILL or RUN, enable_req=0 SHALL force BYPASS next cycle, overriding any other transition; beats arriving in that cycle are handled per the current state.
REQ-018 Output stage: single-entry register; a forwarded beat loads the register and sets out_tvalid the next cycle (latency 1).
REQ-019 A beat SHALL be accepted by the output stage if the register is empty or out_tready=1 in the same cycle; simultaneous load and drain keeps out_tvalid=1 with the new data.
REQ-020 A forwarded beat arriving while the register is full and out_tready=0 SHALL be dropped, leave the register unchanged and increment drop_count, saturating at 0xFFFF.
REQ-021 out_tdata SHALL hold stable while out_tvalid=1 and out_tready=0.
REQ-022 Discarded beats (CLEAR/FILL) SHALL NOT count as drops.
REQ-023 Any beat already held in the register at a state change SHALL still be delivered.

Reset
REQ-024 With areset=1 at a clock edge, the next state SHALL be: BYPASS, fill counter 0, out_tvalid=0, out_tdata=0, drop_count=0, diff_enable=0, diff_aresetn=1.
REQ-025 Reset mid-FILL or mid-RUN SHALL abandon the sequence; a pending output beat SHALL be lost and not counted.

Configuration
REQ-026 The macro AXIS_DIFF_CTRL_DROP_CNT_EN SHALL compile the drop counter in; when it is defined, behaviour is per REQ-020.
REQ-027 When AXIS_DIFF_CTRL_DROP_CNT_EN is undefined, drop_count SHALL be constant 0 and no counter logic SHALL be generated; drop behaviour is unchanged.

Verification
REQ-028 The bench SHALL cover: reset, enable_req=0, 10 in beats 1..10, out_tready=1 -> out data 1..10, each 1 cycle later; state=0.
REQ-029 The bench SHALL cover: enable_req 0->1, FILL_BEATS=6, continuous beats 1..12 -> diff_aresetn low 1 cycle; beats in CLEAR plus the first 6 FILL beats discarded; remaining beats emerge in order; state reaches 3.
REQ-030 The bench SHALL cover: RUN, out_tready=0, 4 beats -> first beat held in the register, out_tdata stable; drop_count=3 with the macro defined, 0 without it.
REQ-031 The bench SHALL cover: enable_req dropped after the 3rd FILL beat -> BYPASS next cycle, diff_enable=0, the next beat forwarded, fill counter restarts on the next enable.
REQ-032 The bench SHALL cover: out_tready=0 for 70000 forwarded beats -> drop_count saturates at 0xFFFF.
REQ-033 The bench SHALL cover: areset pulsed in RUN with out_tvalid=1 -> out_tvalid=0, state=0, drop_count=0 the next cycle.
